// File: rtl/screen_arbiter_pkg.sv
// screen_pkg: shared types for the screen arbiter slice.
//   NDIGITS      - digits on the seven-segment screen
//   digit_t      - one 4-bit digit code
//   screen_img_t - full screen image, digit 0 in the LSBs
//   arb_state_t  - arbiter FSM states (IDLE / SHOW / GAP)
// Optional feature macro used by this slice: SCREEN_ARB_PRIORITY_EN.
package screen_pkg;

  localparam int NDIGITS = 8;

  typedef logic [3:0] digit_t;
  typedef logic [NDIGITS-1:0][3:0] screen_img_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Index width that stays legal for a single client.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/screen_arbiter_if.sv
// screen_arbiter_if: client-side request bundle and screen-side outputs.
//   req/req_en/req_display/req_dots : per-client request and digit image
//   grant/owner/busy                : arbitration result
//   en/display/dots                 : registered image for the screen driver
// Handshake: req is a level held by a client for as long as it wants the
// screen; grant is a level meaning "your image, sampled one cycle earlier,
// is on the screen now". Dropping req ends the tenure on the next edge.
// There is no separate ready; grant is the only response.
interface screen_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*8-1:0]  req_en;
  logic [NREQ*32-1:0] req_display;
  logic [NREQ*8-1:0]  req_dots;

  logic [NREQ-1:0]    grant;
  logic [OW-1:0]      owner;
  logic               busy;
  logic [7:0]         en;
  logic [31:0]        display;
  logic [7:0]         dots;

  modport master (
    output req, req_en, req_display, req_dots,
    input  grant, owner, busy, en, display, dots
  );

  modport slave (
    input  req, req_en, req_display, req_dots,
    output grant, owner, busy, en, display, dots
  );

endinterface

// File: rtl/screen_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req     - request vector
//   i_ptr     - first index to consider (wraps modulo NREQ)
//   i_urgent0 - (SCREEN_ARB_PRIORITY_EN only) client 0 wins if requesting
//   o_found   - at least one request is set
//   o_idx     - chosen requester, first at or after i_ptr
module rr_pick #(
  parameter int NREQ = 4,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_ptr,
`ifdef SCREEN_ARB_PRIORITY_EN
  input  logic            i_urgent0,
`endif
  output logic            o_found,
  output logic [OW-1:0]   o_idx
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    // Scan from the farthest offset down so the nearest requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_found = 1'b1;
        o_idx   = OW'((int'(i_ptr) + k) % NREQ);
      end
    end
`ifdef SCREEN_ARB_PRIORITY_EN
    if (i_urgent0 && i_req[0]) begin
      o_found = 1'b1;
      o_idx   = '0;
    end
`endif
  end

endmodule

// File: rtl/screen_arbiter.sv
// screen_arbiter: shares the 8-digit screen path between NREQ clients.
// Round-robin grant, minimum dwell per owner while others wait, and BLANK
// dark cycles between owners. All outputs are registered.
//   clock, rst   - clock and synchronous active-high reset
//   bus (slave)  - client requests/images in; grant/owner/busy and
//                  en/display/dots out
//   o_dbg_state  - FSM state
//   o_dbg_ptr    - round-robin pointer
// Optional macro SCREEN_ARB_PRIORITY_EN: client 0 preempts immediately and
// wins the arbitration at the end of the gap.
module screen_arbiter
  import screen_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = 50000000,
  parameter int BLANK = 4,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  screen_arbiter_if.slave      bus,
  output arb_state_t           o_dbg_state,
  output logic [OW-1:0]        o_dbg_ptr
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GW = (BLANK > 1) ? $clog2(BLANK) : 1;

  arb_state_t        r_state, w_next_state;
  logic [OW-1:0]     r_ptr, w_ptr_d;
  logic [OW-1:0]     r_owner, w_owner_d;
  logic [DW-1:0]     r_dwell, w_dwell_d;
  logic [GW-1:0]     r_gap, w_gap_d;
  logic [NREQ-1:0]   r_grant, w_grant_d;
  logic              r_busy, w_busy_d;
  logic [7:0]        r_en, w_en_d;
  logic [31:0]       r_display, w_display_d;
  logic [7:0]        r_dots, w_dots_d;

  logic              w_pick_found;
  logic [OW-1:0]     w_pick_idx;
  logic [OW-1:0]     w_sel;
  logic              w_owner_req;
  logic              w_others;
  logic              w_leave;
  logic              w_arb_edge;

  // Arbitration is only evaluated in IDLE and on the last GAP cycle.
  assign w_arb_edge = (r_state == IDLE) || ((r_state == GAP) && (r_gap == '0));

`ifdef SCREEN_ARB_PRIORITY_EN
  logic w_urgent0;
  assign w_urgent0 = (r_state == GAP);
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
`ifdef SCREEN_ARB_PRIORITY_EN
    .i_urgent0 (w_urgent0),
`endif
    .o_found   (w_pick_found),
    .o_idx     (w_pick_idx)
  );

  assign w_owner_req = bus.req[r_owner];
  // r_grant is the owner's one-hot in SHOW, so this masks the owner out.
  assign w_others    = |(bus.req & ~r_grant);

  always_comb begin
    w_leave = (r_state == SHOW) &&
              (!w_owner_req || ((r_dwell == '0) && w_others));
`ifdef SCREEN_ARB_PRIORITY_EN
    if ((r_state == SHOW) && bus.req[0] && (r_owner != '0)) begin
      w_leave = 1'b1;
    end
`endif
  end

  // Image source: the live owner in SHOW, the winner on an arbitration edge.
  assign w_sel = (r_state == SHOW) ? r_owner : w_pick_idx;

  // State register (all registers, outputs included).
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_dwell   <= '0;
      r_gap     <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_en      <= '0;
      r_display <= '0;
      r_dots    <= '0;
    end else begin
      r_state   <= w_next_state;
      r_ptr     <= w_ptr_d;
      r_owner   <= w_owner_d;
      r_dwell   <= w_dwell_d;
      r_gap     <= w_gap_d;
      r_grant   <= w_grant_d;
      r_busy    <= w_busy_d;
      r_en      <= w_en_d;
      r_display <= w_display_d;
      r_dots    <= w_dots_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_pick_found) w_next_state = SHOW;
      SHOW: if (w_leave) w_next_state = GAP;
      GAP:  if (r_gap == '0) w_next_state = w_pick_found ? SHOW : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    w_ptr_d     = r_ptr;
    w_owner_d   = r_owner;
    w_dwell_d   = r_dwell;
    w_gap_d     = r_gap;
    w_grant_d   = r_grant;
    w_busy_d    = r_busy;
    w_en_d      = r_en;
    w_display_d = r_display;
    w_dots_d    = r_dots;

    if (r_state == SHOW) begin
      if (w_leave) begin
        w_grant_d   = '0;
        w_busy_d    = 1'b0;
        w_en_d      = '0;
        w_display_d = '0;
        w_dots_d    = '0;
        w_gap_d     = GW'(BLANK - 1);
        w_ptr_d     = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
      end else begin
        w_en_d      = bus.req_en[int'(w_sel)*8 +: 8];
        w_display_d = bus.req_display[int'(w_sel)*32 +: 32];
        w_dots_d    = bus.req_dots[int'(w_sel)*8 +: 8];
        if (r_dwell != '0) w_dwell_d = r_dwell - 1'b1;
      end
    end else if ((r_state == GAP) && (r_gap != '0)) begin
      w_gap_d = r_gap - 1'b1;
    end else if (w_arb_edge && w_pick_found) begin
      w_grant_d             = '0;
      w_grant_d[w_pick_idx] = 1'b1;
      w_owner_d             = w_pick_idx;
      w_busy_d              = 1'b1;
      w_dwell_d             = DW'(DWELL - 1);
      w_en_d                = bus.req_en[int'(w_sel)*8 +: 8];
      w_display_d           = bus.req_display[int'(w_sel)*32 +: 32];
      w_dots_d              = bus.req_dots[int'(w_sel)*8 +: 8];
    end
  end

  assign bus.grant   = r_grant;
  assign bus.owner   = r_owner;
  assign bus.busy    = r_busy;
  assign bus.en      = r_en;
  assign bus.display = r_display;
  assign bus.dots    = r_dots;

  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_screen_arbiter.sv
// tb_screen_arbiter: self-checking bench for screen_arbiter
// (NREQ=4, DWELL=4, BLANK=2). Directed scenarios plus a random phase; a
// reference model predicts each cycle's outputs into exp_q.
module tb_screen_arbiter;
  import screen_pkg::*;

  localparam int NREQ  = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int OW    = 2;
  localparam int VW    = 57;
`ifdef SCREEN_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  screen_arbiter_if #(.NREQ(NREQ)) bus ();
  arb_state_t     dbg_state;
  logic [OW-1:0]  dbg_ptr;

  screen_arbiter #(.NREQ(NREQ), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clock       (clock),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_ptr   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] img [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h1357_9BDF, 32'h2468_ACE0};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state = 0;  // 0 idle, 1 show, 2 gap
  int          m_ptr = 0, m_dwell = 0, m_gap = 0, m_owner = 0;
  logic [3:0]  m_grant = '0;
  logic        m_busy = 1'b0;
  logic [7:0]  m_en = '0, m_dots = '0;
  logic [31:0] m_disp = '0;

  function automatic int m_pick(input logic [3:0] rq, input int ptr, input bit urgent);
    if (urgent && rq[0]) return 0;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic m_show(input int w);
    m_grant = 4'b0001 << w;
    m_owner = w;
    m_busy  = 1'b1;
    m_en    = bus.req_en[w*8 +: 8];
    m_disp  = bus.req_display[w*32 +: 32];
    m_dots  = bus.req_dots[w*8 +: 8];
  endtask

  task automatic m_dark();
    m_grant = '0; m_busy = 1'b0; m_en = '0; m_disp = '0; m_dots = '0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    int  w;
    bit  leave;
    logic [3:0] others;
    if (rst) begin
      m_state = 0; m_ptr = 0; m_dwell = 0; m_gap = 0; m_owner = 0;
      m_dark();
      return;
    end
    if (m_state == 1) begin
      others = bus.req & ~(4'b0001 << m_owner);
      leave  = !bus.req[m_owner] || (m_dwell == 0 && others != 0);
      if (PRIO && bus.req[0] && m_owner != 0) leave = 1'b1;
      if (leave) begin
        m_dark();
        m_state = 2;
        m_gap   = BLANK - 1;
        m_ptr   = (m_owner + 1) % NREQ;
      end else begin
        m_show(m_owner);
        if (m_dwell > 0) m_dwell--;
      end
    end else if (m_state == 2 && m_gap > 0) begin
      m_gap--;
    end else begin
      w = m_pick(bus.req, m_ptr, PRIO && m_state == 2);
      if (w >= 0) begin
        m_show(w);
        m_state = 1;
        m_dwell = DWELL - 1;
      end else begin
        m_state = 0;
      end
    end
  endtask

  function automatic logic [VW-1:0] m_pack();
    return {2'(m_state), m_grant, (m_busy ? 2'(m_owner) : 2'b00), m_busy,
            m_en, m_disp, m_dots};
  endfunction

  function automatic logic [VW-1:0] dut_pack();
    return {dbg_state, bus.grant, (bus.busy ? bus.owner : 2'b00), bus.busy,
            bus.en, bus.display, bus.dots};
  endfunction

  // ---------------- driver ----------------
  // Inputs are stable here (after a negedge); predict, clock, compare.
  task automatic cycle();
    model_step();
    exp_q.push_back(m_pack());
    @(posedge clock);
    @(negedge clock);
    check("out", 64'(dut_pack()), 64'(exp_q.pop_front()));
  endtask

  task automatic set_images();
    for (int c = 0; c < NREQ; c++) begin
      bus.req_display[c*32 +: 32] = img[c];
      bus.req_en[c*8 +: 8]        = 8'hF0 | 8'(c);
      bus.req_dots[c*8 +: 8]      = 8'(1 << c);
    end
  endtask

  logic [3:0] exp_g [13] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                             4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h1};

  initial begin
    bus.req = '0;
    set_images();
    @(negedge clock);

    // Reset with client 2 requesting, then one-cycle grant latency.
    rst = 1'b1; bus.req = 4'b0100;
    cycle();
    check("t1_rst_grant", 64'(bus.grant), 64'(0));
    check("t1_rst_en", 64'(bus.en), 64'(0));
    rst = 1'b0;
    cycle();
    check("t1_grant", 64'(bus.grant), 64'(4'b0100));
    check("t1_owner", 64'(bus.owner), 64'(2));
    check("t1_display", 64'(bus.display), 64'(img[2]));

    // Two clients held from reset: dwell, gap, alternate.
    rst = 1'b1; bus.req = 4'b0011;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      check("t2_grant", 64'(bus.grant), 64'(exp_g[i]));
    end

    // Reset pulse during SHOW (ptr is 2 at this point).
    rst = 1'b1;
    cycle();
    check("t5_grant", 64'(bus.grant), 64'(0));
    check("t5_en", 64'(bus.en), 64'(0));
    check("t5_busy", 64'(bus.busy), 64'(0));
    check("t5_state", 64'(dbg_state), 64'(IDLE));
    check("t5_ptr", 64'(dbg_ptr), 64'(0));
    rst = 1'b0;

    // Lone client keeps the screen; image changes follow one cycle later.
    rst = 1'b1; bus.req = 4'b0010;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) bus.req_display[63:32] = 32'h8765_4321;
      cycle();
      check("t3_grant", 64'(bus.grant), 64'(4'b0010));
      if (i == 10) check("t3_follow", 64'(bus.display), 64'(32'h8765_4321));
    end
    set_images();

    // Owner drops request at dwell=2; pending client 3 after the gap.
    rst = 1'b1; bus.req = 4'b1001;
    cycle();
    rst = 1'b0;
    cycle();
    check("t4_first", 64'(bus.grant), 64'(4'b0001));
    cycle();
    bus.req = 4'b1000;
    cycle();
    check("t4_gap0", 64'(bus.grant), 64'(0));
    check("t4_gap0_en", 64'(bus.en), 64'(0));
    cycle();
    check("t4_gap1", 64'(bus.grant), 64'(0));
    cycle();
    check("t4_grant3", 64'(bus.grant), 64'(4'b1000));
    check("t4_owner3", 64'(bus.owner), 64'(3));

`ifdef SCREEN_ARB_PRIORITY_EN
    // Urgent client 0 preempts client 2 despite dwell and client 3.
    rst = 1'b1; bus.req = 4'b0100;
    cycle();
    rst = 1'b0;
    cycle();
    bus.req = 4'b1101;
    cycle();
    check("p_gap", 64'(bus.grant), 64'(0));
    cycle();
    check("p_gap1", 64'(bus.grant), 64'(0));
    cycle();
    check("p_grant0", 64'(bus.grant), 64'(4'b0001));
`endif

    // Random traffic against the model.
    rst = 1'b1; bus.req = '0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) begin
        int c;
        c = $urandom_range(0, NREQ - 1);
        bus.req_display[c*32 +: 32] = $urandom;
        bus.req_en[c*8 +: 8]        = 8'($urandom_range(0, 255));
        bus.req_dots[c*8 +: 8]      = 8'($urandom_range(0, 255));
      end
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
